sysbus_arbiter: RTL and testbench
=================================

# sysbus_arbiter

Central arbiter for the shared system bus: collects bus requests (`breq`) from up to `NUM_MASTERS` bus-master bridges and returns a registered one-hot `bgrant`. Ownership is round-robin and held for the owner's whole request. The bus is never taken from a master with a transfer still in flight. The arbiter sits between the master bridges and the bus mux, and drives the mux select (`grant_id`) alongside the grants.

## Interface
- `NUM_MASTERS`, 2: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 256: ownership watchdog limit, in cycles. Used only when the timeout feature is compiled in.
- `clk`  in  1  bus clock; rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `breq`  in  NUM_MASTERS  request per master; held high for as long as the master wants the bus.
- `m_valid`  in  1  muxed master valid currently on the bus.
- `ready`  in  1  slave ready/response strobe on the bus.
- `bgrant`  out  NUM_MASTERS  one-hot or zero grant vector; registered.
- `grant_id`  out  max(1,$clog2(NUM_MASTERS))  index of the current owner; registered.
- `bus_busy`  out  1  high while any grant is asserted.
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant; constant 0 when the feature is compiled out.

## Operation
- **States:** IDLE, GRANTED, RELEASE.
- **IDLE:**
  - If any `breq` bit is high, select a winner by round-robin and go to GRANTED.
  - The search starts at index `last_owner+1` (mod NUM_MASTERS).
  - After reset `last_owner = NUM_MASTERS-1`, so master 0 has first priority.
- **GRANTED:**
  - `bgrant[owner]=1`, `grant_id=owner`, `bus_busy=1`.
- **In-flight flag:**
  - Set on a cycle with `m_valid & ~ready`.
  - Cleared on a cycle with `ready`.
  - A cycle with `m_valid & ready` completes a transfer and leaves the flag clear.
- **Release:**
  - When `breq[owner]=0` and the in-flight flag is clear (including a `ready` seen in the same cycle), go to RELEASE.
  - On release, `last_owner` updates to `owner`.
  - If `breq[owner]` drops while in flight, the grant is held until `ready`.
- **RELEASE:**
  - Exactly one dead cycle with all grants 0 and `bus_busy=0`.
  - Then arbitrate as in IDLE: go to GRANTED if any request is high, else go to IDLE.
- **Request changes:**
  - Requests that rise or fall while another master owns the bus have no effect until the next arbitration.
  - A non-owner may re-request at any time.
- **Reset values:**
  - `bgrant=0`, `grant_id=0`, `bus_busy=0`, `timeout=0`, state IDLE, in-flight flag 0.
  - Any reset mid-transfer returns these values immediately (asynchronous) and discards the ownership.

## Timing
- IDLE to grant: `breq` sampled high at edge t gives `bgrant` high after edge t (latency 1).
- Handover:
  - Owner `breq` sampled low at edge t (not in flight): `bgrant` goes 0 after t.
  - The next owner's `bgrant` goes 1 after t+1.
  - Minimum gap between owners is one cycle.
- A sole requester that re-requests after its own release is regranted after the dead cycle; it is not starved, and the round-robin rule still applies.
- Simultaneous requests from IDLE: the nearest index at or after `last_owner+1` wins.
- `grant_id` and `bgrant` always change on the same edge.

## Configuration
- Macro: `SYSBUS_ARB_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit ownership counter clears on grant and on every `m_valid & ready` cycle, and increments otherwise in GRANTED.
  - When it reaches `TIMEOUT_CYCLES-1`, the grant is forced into RELEASE regardless of `breq` or the in-flight flag.
  - At that point `timeout` pulses for 1 cycle, the in-flight flag clears, and `last_owner` updates to the timed-out master.
- **Undefined:** no counter; `timeout` is tied 0; ownership is unbounded.

## Structure
- Package `sysbus_pkg`:
  - `arb_state_t` enum {IDLE, GRANTED, RELEASE}.
  - `SYSBUS_MAX_MASTERS=8`.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `rr_picker`: combinational round-robin selector taking `req` and `last_owner`, and returning `found` and `winner`. It is instantiated once in the arbiter.

## Test plan
- **Single master:** reset, then `breq=2'b01` at cycle 2. Expect `bgrant=01` and `grant_id=0` after the next edge. Drop `breq`; expect `bgrant=00` one cycle later.
- **Contention:** `breq=2'b11` from IDLE after reset. Expect master 0 granted. Master 0 drops `breq`; expect 1 dead cycle, then `bgrant=10` and `grant_id=1`. Master 1 drops `breq`, master 0 re-requests; expect `bgrant=01` after the dead cycle.
- **In-flight hold:**
  - Owner 0 asserts `m_valid` with `ready=0`, then drops `breq` 2 cycles later.
  - Expect `bgrant=01` held until `ready=1` is seen.
  - Then expect release on the next edge.
- **Asynchronous reset:** assert `rst` mid-grant between clock edges. Expect `bgrant=0`, `bus_busy=0` and `grant_id=0` immediately. After release, with `breq=2'b10`, expect master 1 granted in 1 cycle.
- **Timeout (macro defined, TIMEOUT_CYCLES=8):**
  - Owner holds `breq` with no transfers.
  - Expect `timeout` to pulse after 8 granted cycles.
  - Expect `bgrant=0` for 1 cycle, then the other requester granted.
- **Timeout (macro undefined):** the same stimulus held for 300 cycles keeps `bgrant=01`, and `timeout` stays 0.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared definitions for the system bus arbiter.
//   arb_state_t            : arbiter FSM states
//   SYSBUS_MAX_MASTERS     : largest supported requester count
//   DEFAULT_TIMEOUT_CYCLES : default ownership watchdog limit
//   id_width()             : width of a master index, never less than 1
package sysbus_pkg;

    localparam int unsigned SYSBUS_MAX_MASTERS     = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        RELEASE
    } arb_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// System bus arbitration interface.
//   breq     : per-master bus request
//   m_valid  : muxed master valid on the bus
//   ready    : slave ready/response strobe
//   bgrant   : one-hot (or zero) grant vector
//   grant_id : index of current owner (bus mux select)
//   bus_busy : any grant asserted
//   timeout  : watchdog revoke pulse
// Modports: master (bridge/bus side), slave (arbiter side).
interface sysbus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2
);

    localparam int unsigned IdW = sysbus_pkg::id_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] breq;
    logic                   m_valid;
    logic                   ready;
    logic [NUM_MASTERS-1:0] bgrant;
    logic [IdW-1:0]         grant_id;
    logic                   bus_busy;
    logic                   timeout;

    modport master (
        output breq, m_valid, ready,
        input  bgrant, grant_id, bus_busy, timeout
    );

    modport slave (
        input  breq, m_valid, ready,
        output bgrant, grant_id, bus_busy, timeout
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   req        : request vector
//   last_owner : index of the previous owner; search starts at last_owner+1
//   found      : at least one request is high
//   winner     : nearest requesting index at or after last_owner+1 (mod NUM_MASTERS)
module rr_picker
    import sysbus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    localparam int unsigned IdW = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IdW-1:0]         last_owner,
    output logic                   found,
    output logic [IdW-1:0]         winner
);

    logic [IdW-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = IdW'((int'(last_owner) + i) % NUM_MASTERS);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin system bus arbiter with in-flight transfer protection.
// Ports:
//   clk : bus clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sysbus_arbiter_if.slave (breq/m_valid/ready in; bgrant/grant_id/bus_busy/timeout out)
// Optional ownership watchdog compiled in with macro SYSBUS_ARB_TIMEOUT_EN.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic             clk,
    input logic             rst,
    sysbus_arbiter_if.slave bus
);

    localparam int unsigned IdW = id_width(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > SYSBUS_MAX_MASTERS) begin : g_bad_cfg
        $error("sysbus_arbiter: NUM_MASTERS out of range");
    end

    arb_state_t             state_q, state_d;
    logic [IdW-1:0]         owner_q, owner_d;
    logic [IdW-1:0]         last_owner_q, last_owner_d;
    logic                   inflight_q, inflight_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [IdW-1:0]         grant_id_q, grant_id_d;
    logic                   found;
    logic [IdW-1:0]         winner;
    logic                   xfer_busy;
    logic                   expire;

    rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req       (bus.breq),
        .last_owner(last_owner_q),
        .found     (found),
        .winner    (winner)
    );

`ifdef SYSBUS_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q;

    // Counter idles at 0 outside GRANTED, so it starts from 0 on every grant.
    always_comb begin
        cnt_d = '0;
        if (state_q == GRANTED && !(bus.m_valid && bus.ready)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign expire = (state_q == GRANTED) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= expire;
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expire             = 1'b0;
    assign bus.timeout        = 1'b0;
`endif

    // Flag as it will stand after this cycle: ready clears, m_valid alone sets.
    assign xfer_busy = bus.ready ? 1'b0 : (bus.m_valid | inflight_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        inflight_d   = inflight_q;
        bgrant_d     = bgrant_q;
        grant_id_d   = grant_id_q;
        unique case (state_q)
            IDLE, RELEASE: begin
                inflight_d = 1'b0;
                bgrant_d   = '0;
                if (found) begin
                    state_d    = GRANTED;
                    owner_d    = winner;
                    grant_id_d = winner;
                    bgrant_d   = NUM_MASTERS'(1) << winner;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANTED: begin
                inflight_d = xfer_busy;
                if (expire || (!bus.breq[owner_q] && !xfer_busy)) begin
                    state_d      = RELEASE;
                    bgrant_d     = '0;
                    last_owner_d = owner_q;
                    inflight_d   = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                bgrant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IdW'(NUM_MASTERS - 1);
            inflight_q   <= 1'b0;
            bgrant_q     <= '0;
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            inflight_q   <= inflight_d;
            bgrant_q     <= bgrant_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign bus.bgrant   = bgrant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.bus_busy = |bgrant_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed self-checking bench for sysbus_arbiter with two masters.
module tb_sysbus_arbiter;

`ifdef SYSBUS_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 256;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sysbus_arbiter_if #(.NUM_MASTERS(2)) bus ();

    sysbus_arbiter #(
        .NUM_MASTERS   (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.breq    = 2'b00;
        bus.m_valid = 1'b0;
        bus.ready   = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL reset_bgrant: got %b expected 00", bus.bgrant);
        end
        checks++;
        if (bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL reset_grant_id: got %b expected 0", bus.grant_id);
        end
        checks++;
        if (bus.bus_busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++; $display("FAIL reset_busy_timeout: got %b%b expected 00", bus.bus_busy,
                               bus.timeout);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_master();
        bus.breq = 2'b01;
        tick();
        checks++;
        if (bus.bgrant !== 2'b01 || bus.grant_id !== 1'b0 || bus.bus_busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: got bgrant=%b id=%b busy=%b expected 01/0/1",
                               bus.bgrant, bus.grant_id, bus.bus_busy);
        end
        bus.breq = 2'b00;
        tick();
        checks++;
        if (bus.bgrant !== 2'b00 || bus.bus_busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got bgrant=%b busy=%b expected 00/0",
                               bus.bgrant, bus.bus_busy);
        end
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        bus.breq = 2'b11;
        tick();
        checks++;
        if (bus.bgrant !== 2'b01 || bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL contention_first: got %b id=%b expected 01 id=0",
                               bus.bgrant, bus.grant_id);
        end
        bus.breq = 2'b10;
        tick();
        checks++;
        if (bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL contention_dead1: got %b expected 00", bus.bgrant);
        end
        tick();
        checks++;
        if (bus.bgrant !== 2'b10 || bus.grant_id !== 1'b1) begin
            errors++; $display("FAIL contention_second: got %b id=%b expected 10 id=1",
                               bus.bgrant, bus.grant_id);
        end
        bus.breq = 2'b01;
        tick();
        checks++;
        if (bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL contention_dead2: got %b expected 00", bus.bgrant);
        end
        tick();
        checks++;
        if (bus.bgrant !== 2'b01 || bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL contention_third: got %b id=%b expected 01 id=0",
                               bus.bgrant, bus.grant_id);
        end
        // Master 0 was last owner, so master 1 wins a simultaneous request.
        bus.breq = 2'b00;
        tick();
        tick();
        bus.breq = 2'b11;
        tick();
        checks++;
        if (bus.bgrant !== 2'b10 || bus.grant_id !== 1'b1) begin
            errors++; $display("FAIL contention_rr: got %b id=%b expected 10 id=1",
                               bus.bgrant, bus.grant_id);
        end
        bus.breq = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_inflight();
        apply_reset();
        bus.breq = 2'b01;
        tick();
        bus.m_valid = 1'b1;
        bus.ready   = 1'b0;
        tick();
        tick();
        bus.breq = 2'b00;
        tick();
        checks++;
        if (bus.bgrant !== 2'b01) begin
            errors++; $display("FAIL inflight_hold1: got %b expected 01", bus.bgrant);
        end
        tick();
        checks++;
        if (bus.bgrant !== 2'b01) begin
            errors++; $display("FAIL inflight_hold2: got %b expected 01", bus.bgrant);
        end
        bus.ready = 1'b1;
        tick();
        checks++;
        if (bus.bgrant !== 2'b00 || bus.bus_busy !== 1'b0) begin
            errors++; $display("FAIL inflight_release: got %b busy=%b expected 00/0",
                               bus.bgrant, bus.bus_busy);
        end
        bus.m_valid = 1'b0;
        bus.ready   = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.breq = 2'b01;
        tick();
        // Completed transfer (m_valid & ready) leaves nothing in flight.
        bus.m_valid = 1'b1;
        bus.ready   = 1'b1;
        tick();
        bus.m_valid = 1'b0;
        bus.ready   = 1'b0;
        bus.breq    = 2'b00;
        tick();
        checks++;
        if (bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL b2b_release: got %b expected 00", bus.bgrant);
        end
        // Sole requester re-requests during its dead cycle.
        bus.breq = 2'b01;
        tick();
        checks++;
        if (bus.bgrant !== 2'b01 || bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL b2b_regrant: got %b id=%b expected 01 id=0",
                               bus.bgrant, bus.grant_id);
        end
        // New transfer starting in the same cycle breq drops must hold the grant.
        bus.breq    = 2'b00;
        bus.m_valid = 1'b1;
        tick();
        checks++;
        if (bus.bgrant !== 2'b01) begin
            errors++; $display("FAIL b2b_start_hold: got %b expected 01", bus.bgrant);
        end
        bus.m_valid = 1'b0;
        bus.ready   = 1'b1;
        tick();
        bus.ready = 1'b0;
        checks++;
        if (bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL b2b_start_release: got %b expected 00", bus.bgrant);
        end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.breq = 2'b10;
        tick();
        checks++;
        if (bus.bgrant !== 2'b10 || bus.grant_id !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got %b id=%b expected 10 id=1",
                               bus.bgrant, bus.grant_id);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.bgrant !== 2'b00 || bus.bus_busy !== 1'b0 || bus.grant_id !== 1'b0) begin
            errors++; $display("FAIL areset_now: got %b busy=%b id=%b expected 00/0/0",
                               bus.bgrant, bus.bus_busy, bus.grant_id);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (bus.bgrant !== 2'b10 || bus.grant_id !== 1'b1) begin
            errors++; $display("FAIL areset_regrant: got %b id=%b expected 10 id=1",
                               bus.bgrant, bus.grant_id);
        end
        bus.breq = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        apply_reset();
        bus.breq = 2'b11;
        tick();
        checks++;
        if (bus.bgrant !== 2'b01) begin
            errors++; $display("FAIL timeout_grant: got %b expected 01", bus.bgrant);
        end
`ifdef SYSBUS_ARB_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.bgrant !== 2'b01 || bus.timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL timeout_hold: got %0d bad cycles expected 0", bad);
        end
        tick();
        checks++;
        if (bus.timeout !== 1'b1 || bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL timeout_pulse: got timeout=%b bgrant=%b expected 1/00",
                               bus.timeout, bus.bgrant);
        end
        tick();
        checks++;
        if (bus.timeout !== 1'b0 || bus.bgrant !== 2'b10 || bus.grant_id !== 1'b1) begin
            errors++; $display("FAIL timeout_next: got timeout=%b bgrant=%b id=%b expected 0/10/1",
                               bus.timeout, bus.bgrant, bus.grant_id);
        end
`else
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.bgrant !== 2'b01 || bus.timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL notimeout_hold: got %0d bad cycles expected 0", bad);
        end
        bus.breq = 2'b10;
        tick();
        checks++;
        if (bus.bgrant !== 2'b00) begin
            errors++; $display("FAIL notimeout_release: got %b expected 00", bus.bgrant);
        end
        tick();
        checks++;
        if (bus.bgrant !== 2'b10) begin
            errors++; $display("FAIL notimeout_next: got %b expected 10", bus.bgrant);
        end
`endif
        bus.breq = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_master();
        test_contention();
        test_inflight();
        test_back_to_back();
        test_async_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
